seq_mult_abortable: RTL and testbench

//  Parametrised shift-add sequential multiplier with start/done handshake and a

---
 rtl/seq_mult_abortable.sv | 145 ++++++++++++++
 tb/tb_seq_mult_abortable.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_abortable.sv
// Shift-add sequential multiplier with start/done handshake and synchronous abort.
// Optional two's-complement operation is enabled by defining MULT_SIGNED_EN.
module seq_mult_abortable #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mult_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   acc_next_s;
  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [2*WIDTH-1:0]   result_s;

`ifdef MULT_SIGNED_EN
  logic                 sign_r;

  // Magnitude of a two's-complement operand; the most negative value maps to 2**(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v);
    mag_f = v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Two's-complement negation of the full-width accumulator.
  function automatic logic [2*WIDTH-1:0] neg_f(input logic [2*WIDTH-1:0] v);
    neg_f = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Operand magnitudes and signed result selection.
  always_comb begin
    a_mag_s  = mag_f(a_in);
    b_mag_s  = mag_f(b_in);
    if (sign_r) begin
      result_s = neg_f(acc_r);
    end else begin
      result_s = acc_r;
    end
  end
`else
  // Unsigned operands pass straight through.
  always_comb begin
    a_mag_s  = a_in;
    b_mag_s  = b_in;
    result_s = acc_r;
  end
`endif

  // One shift-add iteration: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    if (mult_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      mcand_r <= '0;
      mult_r  <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      product <= '0;
`ifdef MULT_SIGNED_EN
      sign_r  <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Abort in IDLE suppresses a simultaneous start without any pulse.
          if (start && !abort) begin
            mcand_r <= {{WIDTH{1'b0}}, a_mag_s};
            mult_r  <= b_mag_s;
            acc_r   <= '0;
            cnt_r   <= '0;
`ifdef MULT_SIGNED_EN
            sign_r  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
`endif
            state_r <= ST_RUN;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_r <= ST_IDLE;
            aborted <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
          end else begin
            acc_r   <= acc_next_s;
            mcand_r <= mcand_r << 1;
            mult_r  <= mult_r >> 1;
            cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            // Fixed latency: always exactly WIDTH iterations.
            if (cnt_r == CNT_W'(WIDTH - 1)) begin
              state_r <= ST_DONE;
              busy    <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          product <= result_s;
          done    <= 1'b1;
          state_r <= ST_IDLE;
          ready   <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          ready   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_abortable.sv
// Directed self-checking bench for seq_mult_abortable at WIDTH=8.
// Expected values follow MULT_SIGNED_EN when the bench is built with it.
module tb_seq_mult_abortable;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] product;

  int n_cmp;
  int n_err;

  seq_mult_abortable #(.WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .a_in    (a_in),
    .b_in    (b_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .product (product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation and check latency, busy length and result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string name);
    int done_k;
    int busy_n;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_accept: busy=%b ready=%b, required busy=1 ready=0", name, busy, ready);
    end
    done_k = -1;
    busy_n = 1;
    for (int k = 1; k <= 20 && done_k < 0; k++) begin
      tick();
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) done_k = k;
      if (done === 1'b1 && aborted === 1'b1) begin
        n_err++;
        $display("FAIL %s_pulse_overlap: done and aborted both 1", name);
      end
    end
    n_cmp++;
    if (done_k != 9) begin
      n_err++;
      $display("FAIL %s_latency: done at cycle %0d, required 9", name, done_k);
    end
    n_cmp++;
    if (busy_n != 8) begin
      n_err++;
      $display("FAIL %s_busy_len: busy for %0d cycles, required 8", name, busy_n);
    end
    n_cmp++;
    if (product !== exp) begin
      n_err++;
      $display("FAIL %s_product: got 0x%04h, required 0x%04h", name, product, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    a_in  = 8'd0;
    b_in  = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({ready, busy, done, aborted} !== 4'b1000 || product !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_state: rdy/bsy/dn/ab=%b product=0x%04h, required 1000 / 0x0000",
               {ready, busy, done, aborted}, product);
    end
    tick();
  endtask

  task automatic test_basic();
    run_op(8'd13, 8'd11, 16'd143, "mul_13x11");
    tick();
  endtask

  task automatic test_max_and_zero();
`ifdef MULT_SIGNED_EN
    run_op(8'd255, 8'd255, 16'h0001, "mul_ffxff");
`else
    run_op(8'd255, 8'd255, 16'hFE01, "mul_ffxff");
`endif
    tick();
    run_op(8'd0, 8'd200, 16'h0000, "mul_0x200");
    tick();
  endtask

  // Abort mid-RUN, then a fresh operation.
  task automatic test_abort();
    int dones;
    run_op(8'd13, 8'd11, 16'd143, "pre_abort");
    tick();
    a_in  = 8'd7;
    b_in  = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pulse: aborted=%b busy=%b done=%b, required 1 0 0", aborted, busy, done);
    end
    n_cmp++;
    if (product !== 16'd143) begin
      n_err++;
      $display("FAIL abort_product_hold: got %0d, required 143", product);
    end
    tick();
    n_cmp++;
    if (aborted !== 1'b0 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_after: aborted=%b ready=%b, required 0 1", aborted, ready);
    end
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0 || product !== 16'd143) begin
      n_err++;
      $display("FAIL abort_no_done: dones=%0d product=%0d, required 0 / 143", dones, product);
    end
    run_op(8'd2, 8'd3, 16'd6, "post_abort");
    tick();
  endtask

  // Abort arriving while in DONE must not cancel the completion.
  task automatic test_abort_in_done();
    a_in  = 8'd6;
    b_in  = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || aborted !== 1'b0 || product !== 16'd42) begin
      n_err++;
      $display("FAIL abort_in_done: done=%b aborted=%b product=%0d, required 1 0 42",
               done, aborted, product);
    end
    tick();
  endtask

  // Start held high with operands churning; next op accepted right after done.
  task automatic test_back_to_back();
    int dones;
    int done_k;
    a_in  = 8'd3;
    b_in  = 8'd4;
    start = 1'b1;
    tick();
    done_k = -1;
    for (int k = 1; k <= 20 && done_k < 0; k++) begin
      a_in = 8'(k * 17);
      b_in = 8'(k * 29);
      tick();
      if (done === 1'b1) done_k = k;
    end
    n_cmp++;
    if (done_k != 9 || product !== 16'd12) begin
      n_err++;
      $display("FAIL b2b_first: done at %0d product=%0d, required 9 / 12", done_k, product);
    end
    a_in = 8'd5;
    b_in = 8'd6;
    tick();
    start = 1'b0;
    a_in  = 8'd99;
    b_in  = 8'd77;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_issue_rate: busy=%b one cycle after done, required 1", busy);
    end
    dones = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 1 || product !== 16'd30) begin
      n_err++;
      $display("FAIL b2b_second: dones=%0d product=%0d, required 1 / 30", dones, product);
    end
  endtask

  task automatic test_start_abort_idle();
    a_in  = 8'd4;
    b_in  = 8'd4;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || busy !== 1'b0 || aborted !== 1'b0) begin
      n_err++;
      $display("FAIL start_abort_idle: ready=%b busy=%b aborted=%b, required 1 0 0",
               ready, busy, aborted);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    a_in  = 8'd9;
    b_in  = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({ready, busy, done, aborted} !== 4'b1000 || product !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_mid: rdy/bsy/dn/ab=%b product=0x%04h, required 1000 / 0x0000",
               {ready, busy, done, aborted}, product);
    end
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done === 1'b1 || aborted === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL reset_mid_pulses: %0d pulses, required 0", pulses);
    end
  endtask

  task automatic test_signed_vectors();
`ifdef MULT_SIGNED_EN
    run_op(8'hFD, 8'd5, 16'hFFF1, "mul_fd_x5");
`else
    run_op(8'hFD, 8'd5, 16'h04F1, "mul_fd_x5");
`endif
    tick();
    run_op(8'h80, 8'h80, 16'h4000, "mul_80x80");
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    a_in  = 8'd0;
    b_in  = 8'd0;
    test_reset();
    test_basic();
    test_max_and_zero();
    test_abort();
    test_abort_in_done();
    test_back_to_back();
    test_start_abort_idle();
    test_reset_mid();
    test_signed_vectors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
